vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Upstream stage for every background/sprite mapper.
- Generates the raster position (DrawX, DrawY), the active-video flag `blank`, and sync pulses for a 640x480 display with a 25 MHz pixel rate.
- Also produces sync/blank copies delayed by a programmable number of pixels. These stay aligned with the mappers' registered RGB output: ROM read plus output register gives 2 cycles.
- Also produces frame_start, line_start and frame_count, which frame-synchronous logic (state/level selection) uses.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIPE_DELAY, 2, delay in pixel ticks for hs_d/vs_d/blank_d; legal range 0..7

Ports:
- vga_clk  in  1  pixel-domain clock
- reset_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel tick enable; tie high when vga_clk is the 25 MHz pixel clock
- DrawX  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800)
- DrawY  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- blank  out  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- hs_d, vs_d, blank_d  out  1 each  hs/vs/blank delayed PIPE_DELAY ticks
- line_start  out  1  one-tick pulse, high while DrawX==0
- frame_start  out  1  one-tick pulse, high while DrawX==0 and DrawY==0
- frame_count  out  16  count of completed frames; wraps

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (async assert, sync release) forces:
  - DrawX=0, DrawY=0, frame_count=0
  - hs=1, vs=1, hs_d=1, vs_d=1
  - blank=0, blank_d=0, all delay-line stages blank=0
  - line_start=0, frame_start=0
- Counting: the counter advances only on a vga_clk edge with pix_ce=1. With pix_ce=0, every output register and the delay line hold.
  - Horizontal: DrawX increments. At H_TOTAL-1 it wraps to 0 and DrawY increments.
  - Vertical: at DrawX==H_TOTAL-1 and DrawY==V_TOTAL-1, both counters wrap to 0 and frame_count increments (mod 2^16).
- Decode is computed from the next counter values, so blank/hs/vs/line_start/frame_start describe the DrawX/DrawY presented in the same cycle:
  - hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751)
  - vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491)
  - blank=1 iff DrawX<640 and DrawY<480
- Reset exception: position (0,0) held during reset reports blank=0, frame_start=0, line_start=0.
  - First pix_ce tick after release: DrawX=1, DrawY=0, blank=1.
  - The first frame_start occurs at the next frame wrap, 420000 ticks after release.
- Pulses: line_start and frame_start are high for exactly one pix_ce tick. With pix_ce low they hold their value; consumers qualify with pix_ce.
- Delay line:
  - PIPE_DELAY stages of {hs,vs,blank}, shifted on pix_ce.
  - PIPE_DELAY=0 makes the _d outputs equal hs/vs/blank.
  - Out-of-range PIPE_DELAY is an elaboration error.
- frame_count increments in the same tick that frame_start rises. Wraps 0xFFFF to 0x0000.
- Reset asserted mid-line or mid-frame: immediate return to reset values. Delay line cleared; no stale sync pulse emerges after release.

Test Plan:
- Reset then 800 ticks, pix_ce=1:
  - DrawX runs 1..799 then 0; DrawY 0 then 1.
  - hs low exactly at DrawX 656..751 (96 ticks).
  - line_start high only at the wrap tick.
- Full frame (420000 ticks):
  - vs low only for DrawY 490..491 (1600 ticks).
  - blank high on exactly 307199 ticks in the first frame (pixel (0,0) lost to reset), 307200 in the second.
  - frame_start once; frame_count=1.
- PIPE_DELAY=2:
  - hs_d/vs_d/blank_d equal hs/vs/blank two ticks earlier for an entire frame.
  - Rebuild with PIPE_DELAY=0: equal same tick.
- pix_ce toggling 1,0,1,0:
  - Counters advance every other cycle; every output is constant during pix_ce=0 cycles.
  - frame_start stays high for 2 vga_clk cycles across the stalled tick.
- Reset asserted at DrawX=700, DrawY=491 (hs=0, vs=0):
  - Outputs go to reset values asynchronously before the next edge.
  - hs_d/vs_d stay 1 after release until the counter reaches the sync region.
- Force frame_count to 0xFFFF (via bench-preloaded run or hierarchical deposit), complete one frame -> frame_count=0x0000 in the same tick frame_start is high.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, registered sync/blank decode,
// a short delay line that realigns sync with pipelined RGB, and frame bookkeeping.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        hs_d,
    output logic        vs_d,
    output logic        blank_d,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
        end
    endgenerate

    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        vis_q, vis_d;
    logic        line_q, line_d;
    logic        frame_q, frame_d;

    // Decode looks at the next counter values so every flag lines up with
    // the DrawX/DrawY registered on the same edge.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        vis_d       = vis_q;
        line_d      = line_q;
        frame_d     = frame_q;
        if (pix_ce) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d         = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
            hsync_d = !((x_d >= HS_START) && (x_d < HS_END));
            vsync_d = !((y_d >= VS_START) && (y_d < VS_END));
            vis_d   = (x_d < H_VIS) && (y_d < V_VIS);
            line_d  = (x_d == 10'd0);
            frame_d = (x_d == 10'd0) && (y_d == 10'd0);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            vis_q       <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            vis_q       <= vis_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign blank       = vis_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign frame_count = frame_cnt_q;

    // Each stage carries {hs, vs, blank}; stages reset to idle sync levels
    // so nothing stale leaks out after a reset.
    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign hs_d    = hsync_q;
            assign vs_d    = vsync_q;
            assign blank_d = vis_q;
        end else begin : g_delay
            for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
                logic [2:0] stage_q, stage_d;
                logic [2:0] stage_in;
                if (gi == 0) begin : g_head
                    assign stage_in = {hsync_q, vsync_q, vis_q};
                end else begin : g_link
                    assign stage_in = g_stage[gi-1].stage_q;
                end
                always_comb begin
                    stage_d = stage_q;
                    if (pix_ce) begin
                        stage_d = stage_in;
                    end
                end
                always_ff @(posedge vga_clk or negedge reset_n) begin
                    if (!reset_n) begin
                        stage_q <= 3'b110;
                    end else begin
                        stage_q <= stage_d;
                    end
                end
            end
            assign {hs_d, vs_d, blank_d} = g_stage[PIPE_DELAY-1].stage_q;
        end
    endgenerate

endmodule
